// File: rtl/fetch_prefetch_unit.sv
// Fetch/prefetch unit: owns the PC, issues word fetches over req/gnt/rvalid and
// buffers returned instructions in a DEPTH-entry queue that feeds decode.
module fetch_prefetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redir_valid,
    input  logic [1:0]        redir_kind,
    input  logic [ADDR_W-1:0] redir_pc,
    input  logic [15:0]       redir_imm16,
    input  logic [25:0]       redir_target,
    input  logic [ADDR_W-1:0] redir_reg,
    input  logic              redir_zero
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = 8;

    typedef enum logic {RUN, DRAIN} state_t;
    state_t state, state_next;

    logic [ADDR_W-1:0] pc;
    logic [31:0]       q_data [DEPTH];
    logic [ADDR_W-1:0] q_pc   [DEPTH];
    logic [ADDR_W-1:0] a_fifo [DEPTH];
    logic [PW-1:0]     q_rd, q_wr, a_rd, a_wr;
    logic [CW-1:0]     q_cnt, outstanding;
    logic [DW-1:0]     discard, discard_next, stale;

    logic [ADDR_W-1:0] p1, imm_ext, target_pc;
    logic              redir_taken;
    logic [CW:0]       in_use;
    logic              gnt_fire, rsp_keep, rsp_drop, push, pop;

    assign imm_ext = {{(ADDR_W-16){redir_imm16[15]}}, redir_imm16};

    always_comb begin
        p1          = redir_pc + ADDR_W'(1);
        redir_taken = 1'b0;
        target_pc   = redir_reg;
        if (redir_valid) begin
            case (redir_kind)
                2'b00: begin redir_taken = redir_zero;  target_pc = p1 + imm_ext; end
                2'b01: begin redir_taken = !redir_zero; target_pc = p1 + imm_ext; end
                2'b10: begin redir_taken = 1'b1; target_pc = {p1[ADDR_W-1:26], redir_target}; end
                default: begin redir_taken = 1'b1; target_pc = redir_reg; end
            endcase
        end
    end

    // Handshakes: a fetch transfers when imem_req && imem_gnt (imem_addr held
    // stable while req waits); decode takes the head when instr_valid && instr_ready.
    assign in_use      = {1'b0, q_cnt} + {1'b0, outstanding};
    assign imem_req    = rst_n && !redir_taken && (in_use < (CW+1)'(DEPTH));
    assign imem_addr   = pc;
    assign instr_valid = (q_cnt != '0);
    assign instr_data  = q_data[q_rd];
    assign instr_pc    = q_pc[q_rd];

    assign gnt_fire = imem_req && imem_gnt;
    assign rsp_drop = imem_rvalid && (state == DRAIN);
    assign rsp_keep = imem_rvalid && (state == RUN) && (outstanding != '0);
    assign push     = rsp_keep && !redir_taken;
    assign pop      = instr_valid && instr_ready && !redir_taken;

    // Every response still owed at a redirect is stale; one arriving this cycle is dropped now.
    always_comb begin
        stale        = discard + DW'(outstanding);
        discard_next = discard;
        if (redir_taken)
            discard_next = stale - DW'(imem_rvalid && (stale != '0));
        else if (rsp_drop)
            discard_next = discard - 1'b1;
        state_next = (discard_next != '0) ? DRAIN : RUN;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= RUN;
            discard <= '0;
        end else begin
            state   <= state_next;
            discard <= discard_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            q_cnt       <= '0;
            q_rd        <= '0;
            q_wr        <= '0;
            a_rd        <= '0;
            a_wr        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_data[i] <= '0;
                q_pc[i]   <= '0;
                a_fifo[i] <= '0;
            end
        end else if (redir_taken) begin
            pc          <= target_pc;
            outstanding <= '0;
            q_cnt       <= '0;
            q_rd        <= '0;
            q_wr        <= '0;
            a_rd        <= '0;
            a_wr        <= '0;
        end else begin
            if (gnt_fire) begin
                pc           <= pc + ADDR_W'(1);
                a_fifo[a_wr] <= pc;
                a_wr         <= a_wr + 1'b1;
            end
            if (rsp_keep)
                a_rd <= a_rd + 1'b1;
            if (push) begin
                q_data[q_wr] <= imem_rdata;
                q_pc[q_wr]   <= a_fifo[a_rd];
                q_wr         <= q_wr + 1'b1;
            end
            if (pop)
                q_rd <= q_rd + 1'b1;
            q_cnt       <= q_cnt + CW'(push) - CW'(pop);
            outstanding <= outstanding + CW'(gnt_fire) - CW'(rsp_keep);
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: directed steps then random traffic, checked
// against a model of the fetched address stream and an in-order memory.
module tb_fetch_prefetch_unit;

    localparam int          ADDR_W   = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n, imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata, instr_data, instr_pc;
    logic        instr_valid, instr_ready;
    logic        redir_valid, redir_zero;
    logic [1:0]  redir_kind;
    logic [31:0] redir_pc, redir_reg;
    logic [15:0] redir_imm16;
    logic [25:0] redir_target;

    fetch_prefetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc),
        .redir_valid(redir_valid), .redir_kind(redir_kind), .redir_pc(redir_pc),
        .redir_imm16(redir_imm16), .redir_target(redir_target),
        .redir_reg(redir_reg), .redir_zero(redir_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } rsp_t;

    int          total = 0, fails = 0, cyc = 0, total_pops = 0, last_due = 0;
    int          gnt_pct, rdy_pct, lat_min, lat_max;
    logic [31:0] fetch_pc;
    logic [31:0] exp_q[$];
    rsp_t        rsp_q[$];
    logic        s_valid;

    // Inputs requested for the next cycle; applied just after the falling edge.
    logic        nxt_rst_n, nr_valid, nr_zero;
    logic [1:0]  nr_kind;
    logic [31:0] nr_pc, nr_reg;
    logic [15:0] nr_imm;
    logic [25:0] nr_tgt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_redirect(output logic taken, output logic [31:0] tgt);
        logic [31:0] p1;
        p1    = redir_pc + 32'd1;
        taken = 1'b0;
        tgt   = 32'h0;
        if (redir_valid && rst_n) begin
            case (redir_kind)
                2'd0: begin taken = redir_zero;  tgt = p1 + 32'($signed(redir_imm16)); end
                2'd1: begin taken = !redir_zero; tgt = p1 + 32'($signed(redir_imm16)); end
                2'd2: begin taken = 1'b1; tgt = (p1 & 32'hFC00_0000) | 32'(redir_target); end
                default: begin taken = 1'b1; tgt = redir_reg; end
            endcase
        end
    endfunction

    task automatic cycle();
        logic        taken;
        logic [31:0] tgt;
        int          due;
        @(negedge clk);
        rst_n        = nxt_rst_n;
        redir_valid  = nr_valid;
        redir_kind   = nr_kind;
        redir_pc     = nr_pc;
        redir_imm16  = nr_imm;
        redir_target = nr_tgt;
        redir_reg    = nr_reg;
        redir_zero   = nr_zero;
        nr_valid     = 1'b0;
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(rsp_q[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        imem_gnt    = ($urandom_range(0, 99) < gnt_pct);
        instr_ready = ($urandom_range(0, 99) < rdy_pct);
        #1;
        model_redirect(taken, tgt);
        s_valid = instr_valid;
        chk("imem_req", imem_req, rst_n && !taken && (exp_q.size() < DEPTH));
        if (rst_n) begin
            if (imem_req) chk("imem_addr", imem_addr, fetch_pc);
            if (instr_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", instr_valid, 1'b0);
                end else begin
                    chk("instr_pc", instr_pc, exp_q[0]);
                    chk("instr_data", instr_data, mem_word(exp_q[0]));
                    if (instr_ready && !taken) begin
                        void'(exp_q.pop_front());
                        total_pops++;
                    end
                end
            end
            if (imem_rvalid) void'(rsp_q.pop_front());
            if (taken) begin
                exp_q.delete();
                fetch_pc = tgt;
            end else if (imem_req && imem_gnt) begin
                due = cyc + $urandom_range(lat_min, lat_max);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                rsp_q.push_back('{due, fetch_pc});
                exp_q.push_back(fetch_pc);
                fetch_pc = fetch_pc + 32'd1;
            end
        end else begin
            rsp_q.delete();
            exp_q.delete();
            fetch_pc = RESET_PC;
            last_due = 0;
        end
        cyc++;
    endtask

    task automatic redirect(input logic [1:0] kind, input logic [31:0] pc, input logic [15:0] imm,
                            input logic [25:0] tf, input logic [31:0] rg, input logic z);
        nr_valid = 1'b1;
        nr_kind  = kind;
        nr_pc    = pc;
        nr_imm   = imm;
        nr_tgt   = tf;
        nr_reg   = rg;
        nr_zero  = z;
        cycle();
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!s_valid && n < budget);
        chk(tag, s_valid, 1'b1);
    endtask

    initial begin
        int p0, n;
        rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        redir_valid = 1'b0; redir_kind = '0; redir_pc = '0; redir_imm16 = '0;
        redir_target = '0; redir_reg = '0; redir_zero = 1'b0;
        nxt_rst_n = 1'b0; nr_valid = 1'b0; nr_kind = '0; nr_pc = '0; nr_imm = '0;
        nr_tgt = '0; nr_reg = '0; nr_zero = 1'b0;
        gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
        fetch_pc = RESET_PC;

        repeat (3) cycle();
        nxt_rst_n = 1'b1;
        cycle();
        chk("reset_valid", instr_valid, 1'b0);
        chk("reset_data", instr_data, 32'h0);
        chk("reset_pc", instr_pc, 32'h0);
        chk("reset_addr", imem_addr, RESET_PC);

        // Streaming at one instruction per cycle.
        repeat (6) cycle();
        p0 = total_pops;
        repeat (20) cycle();
        chk("throughput", total_pops - p0, 32'd20);

        // Decode stalls: credit stops fetching at DEPTH in use.
        rdy_pct = 0;
        repeat (10) cycle();
        chk("held_in_use", exp_q.size(), DEPTH);
        chk("held_req", imem_req, 1'b0);
        rdy_pct = 100;
        repeat (10) cycle();

        // bne taken: 0x11 - 4 = 0x0D; then the same bne not taken.
        redirect(2'd1, 32'h10, 16'hFFFC, 26'h0, 32'h0, 1'b0);
        cycle();
        chk("bne_addr", imem_addr, 32'h0000_000D);
        chk("bne_flush", instr_valid, 1'b0);
        repeat (8) cycle();
        redirect(2'd1, 32'h10, 16'hFFFC, 26'h0, 32'h0, 1'b1);
        cycle();
        chk("bne_nt_valid", instr_valid, 1'b1);
        repeat (6) cycle();

        // j with several responses in flight.
        lat_min = 3; lat_max = 3;
        repeat (8) cycle();
        redirect(2'd2, 32'h20, 16'h0, 26'h100, 32'h0, 1'b0);
        wait_valid("j_wait", 30);
        chk("j_first_pc", instr_pc, 32'h0000_0100);

        // Redirect-to-first-instruction latency.
        lat_min = 1; lat_max = 1;
        repeat (10) cycle();
        redirect(2'd2, 32'h40, 16'h0, 26'h300, 32'h0, 1'b0);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!s_valid && n < 10);
        chk("redir_latency", n, 32'd3);
        chk("lat_first_pc", instr_pc, 32'h0000_0300);

        // jr to the top of the address space wraps to 0.
        repeat (4) cycle();
        redirect(2'd3, 32'h50, 16'h0, 26'h0, 32'hFFFF_FFFF, 1'b0);
        cycle();
        chk("jr_addr", imem_addr, 32'hFFFF_FFFF);
        cycle();
        chk("jr_wrap", imem_addr, 32'h0000_0000);
        repeat (6) cycle();

        // Second redirect while stale responses are still being discarded.
        lat_min = 4; lat_max = 4;
        repeat (8) cycle();
        redirect(2'd3, 32'h60, 16'h0, 26'h0, 32'h500, 1'b0);
        cycle();
        redirect(2'd2, 32'h70, 16'h0, 26'h200, 32'h0, 1'b0);
        wait_valid("drain_wait", 40);
        chk("drain_first_pc", instr_pc, 32'h0000_0200);

        // Reset mid-stream with a response arriving in the reset cycle.
        lat_min = 1; lat_max = 1;
        repeat (8) cycle();
        nxt_rst_n = 1'b0;
        cycle();
        nxt_rst_n = 1'b1;
        cycle();
        chk("rst_mid_valid", instr_valid, 1'b0);
        chk("rst_mid_addr", imem_addr, RESET_PC);
        repeat (10) cycle();

        // Random traffic with random redirects.
        gnt_pct = 70; rdy_pct = 70; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) < 6) begin
                nr_valid = 1'b1;
                nr_kind  = 2'($urandom_range(0, 3));
                nr_pc    = $urandom;
                nr_imm   = 16'($urandom);
                nr_tgt   = 26'($urandom);
                nr_reg   = $urandom;
                nr_zero  = 1'($urandom_range(0, 1));
            end
            cycle();
        end
        gnt_pct = 100; rdy_pct = 100;
        repeat (20) cycle();

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
